// File: rtl/score_pkg.sv
// Shared constants for the score renderer: FSM encoding, default glyph size,
// background colour and the seven-segment shape of each decimal glyph.
package score_pkg;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVERT = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_PLOT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int DEF_GLYPH_W = 16;
  localparam int DEF_GLYPH_H = 32;
  localparam int BG_COLOUR   = 0;

  // Bit order {g,f,e,d,c,b,a}; codes 10..15 are empty glyphs.
  function automatic logic [6:0] seg_mask(input logic [3:0] d);
    case (d)
      4'd0:    seg_mask = 7'h3F;
      4'd1:    seg_mask = 7'h06;
      4'd2:    seg_mask = 7'h5B;
      4'd3:    seg_mask = 7'h4F;
      4'd4:    seg_mask = 7'h66;
      4'd5:    seg_mask = 7'h6D;
      4'd6:    seg_mask = 7'h7D;
      4'd7:    seg_mask = 7'h07;
      4'd8:    seg_mask = 7'h7F;
      4'd9:    seg_mask = 7'h6F;
      default: seg_mask = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// Synchronous glyph ROM, address {digit,row,col}, one-cycle read latency, no backpressure.
// Contents are a seven-segment font built in logic; lit pixels use colour (digit % 7) + 1.
module digit_glyph_rom
  import score_pkg::*;
#(
  parameter int GLYPH_W  = DEF_GLYPH_W,
  parameter int GLYPH_H  = DEF_GLYPH_H,
  parameter int COLOUR_W = 3,
  localparam int CW = $clog2(GLYPH_W),
  localparam int RW = $clog2(GLYPH_H),
  localparam int AW = 4 + RW + CW
) (
  input  logic                clock,
  input  logic [AW-1:0]       address,
  output logic [COLOUR_W-1:0] q
);

  localparam int T     = (GLYPH_W / 8 > 0) ? GLYPH_W / 8 : 1;
  localparam int HALF  = GLYPH_H / 2;
  localparam int G_TOP = HALF - (T + 1) / 2;

  logic [6:0]          seg;
  logic                lit;
  logic [COLOUR_W-1:0] pix_d;
  int                  r;
  int                  c;

  always_comb begin
    seg = seg_mask(address[AW-1 -: 4]);
    r   = int'(address[CW +: RW]);
    c   = int'(address[CW-1:0]);
    lit = (seg[0] && r < T) ||
          (seg[3] && r >= GLYPH_H - T) ||
          (seg[6] && r >= G_TOP && r < G_TOP + T) ||
          (seg[5] && c < T && r < HALF) ||
          (seg[1] && c >= GLYPH_W - T && r < HALF) ||
          (seg[4] && c < T && r >= HALF) ||
          (seg[2] && c >= GLYPH_W - T && r >= HALF);
    pix_d = lit ? COLOUR_W'(int'(address[AW-1 -: 4]) % 7 + 1) : COLOUR_W'(BG_COLOUR);
  end

  always_ff @(posedge clock) begin
    q <= pix_d;
  end

endmodule

// File: rtl/score_renderer.sv
// Converts a binary score to BCD (one shift per cycle) then plots every glyph pixel, MSD first.
// Two cycles per pixel (FETCH, PLOT); PLOT holds x/y/colour until plot_ready is seen high.
module score_renderer
  import score_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCORE_W    = 14,
  parameter int GLYPH_W    = DEF_GLYPH_W,
  parameter int GLYPH_H    = DEF_GLYPH_H,
  parameter int COLOUR_W   = 3,
  parameter int X_W        = 8,
  parameter int Y_W        = 7,
  parameter int LEAD_BLANK = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [SCORE_W-1:0]  score,
  input  logic [X_W-1:0]      origin_x,
  input  logic [Y_W-1:0]      origin_y,
  input  logic                plot_ready,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int CW = $clog2(GLYPH_W);
  localparam int RW = $clog2(GLYPH_H);
  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int KW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
  localparam int BW = 4 * NUM_DIGITS;
  localparam int AW = 4 + RW + CW;

  localparam logic [31:0]   MAX_VAL  = 32'(10 ** NUM_DIGITS - 1);
  localparam logic [KW-1:0] LAST_CNT = KW'(SCORE_W - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(GLYPH_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(GLYPH_H - 1);
  localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);

  logic [2:0]            state_q, state_d;
  logic [SCORE_W-1:0]    bin_q, bin_d;
  logic [BW-1:0]         bcd_q, bcd_d;
  logic                  sat_q, sat_d;
  logic [KW-1:0]         cnt_q, cnt_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;
  logic [X_W-1:0]        ox_q, ox_d;
  logic [Y_W-1:0]        oy_q, oy_d;

  logic [BW-1:0]         bcd_adj;
  logic [NUM_DIGITS-1:0] lz;
  logic                  zero_run;
  logic [3:0]            cur_digit;
  logic                  blank;
  logic                  last_pix;
  logic [COLOUR_W-1:0]   rom_q;

  // Add-3 correction on every BCD nibble ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // lz[i]: digits 0..i (MSD first) are all zero.
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run = zero_run && (bcd_q[4*(NUM_DIGITS-1-i) +: 4] == 4'd0);
      lz[i]    = zero_run;
    end
  end

  assign cur_digit = bcd_q[4*(NUM_DIGITS-1-int'(digit_q)) +: 4];
  assign blank     = (LEAD_BLANK != 0) && lz[digit_q] && (digit_q != LAST_DIG);
  assign last_pix  = (digit_q == LAST_DIG) && (row_q == LAST_ROW) && (col_q == LAST_COL);

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    sat_d   = sat_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    row_d   = row_q;
    col_d   = col_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONVERT;
          bin_d   = score;
          sat_d   = (32'(score) > MAX_VAL);
          bcd_d   = '0;
          cnt_d   = '0;
          ox_d    = origin_x;
          oy_d    = origin_y;
        end
      end
      S_CONVERT: begin
        bcd_d = {bcd_adj[BW-2:0], bin_q[SCORE_W-1]};
        bin_d = {bin_q[SCORE_W-2:0], 1'b0};
        cnt_d = cnt_q + KW'(1);
        if (cnt_q == LAST_CNT) begin
          if (sat_q) begin
            bcd_d = {NUM_DIGITS{4'd9}};
          end
          state_d = S_FETCH;
          digit_d = '0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      S_FETCH: state_d = S_PLOT;
      S_PLOT: begin
        if (plot_ready) begin
          if (last_pix) begin
            state_d = S_DONE;
          end else begin
            state_d = S_FETCH;
            col_d   = col_q + CW'(1);
            if (col_q == LAST_COL) begin
              row_d = row_q + RW'(1);
              if (row_q == LAST_ROW) begin
                digit_d = digit_q + DW'(1);
              end
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      digit_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      ox_q    <= '0;
      oy_q    <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      sat_q   <= sat_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      row_q   <= row_d;
      col_q   <= col_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
    end
  end

  digit_glyph_rom #(
    .GLYPH_W  (GLYPH_W),
    .GLYPH_H  (GLYPH_H),
    .COLOUR_W (COLOUR_W)
  ) u_rom (
    .clock   (clock),
    .address ({cur_digit, row_q, col_q}),
    .q       (rom_q)
  );

  // Outputs decode from state so an asynchronous reset silences plot at once.
  assign plot   = (state_q == S_PLOT);
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign x      = plot ? ox_q + X_W'(int'(digit_q) * GLYPH_W) + X_W'(col_q) : '0;
  assign y      = plot ? oy_q + Y_W'(row_q) : '0;
  assign colour = (plot && !blank) ? rom_q : COLOUR_W'(BG_COLOUR);

endmodule

// File: tb/tb_score_renderer.sv
// Scoreboard bench: stimulus pushes expected pixels, negedge monitors pop and compare on accept.
module tb_score_renderer;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic [13:0] score = '0;
  logic [7:0]  origin_x = '0;
  logic [6:0]  origin_y = '0;
  logic        plot_ready = 1'b1;
  logic [7:0]  x_a, x_b;
  logic [6:0]  y_a, y_b;
  logic [2:0]  col_a, col_b;
  logic        plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   pix_a = 0;
  int   pix_b = 0;
  bit   rnd_mode = 1'b0;
  pix_t q_a[$];
  pix_t q_b[$];
  pix_t cur_a, cur_b, held_a, first_a, last_a;
  bit   hold_vld_a = 1'b0;

  string segs[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                      "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  score_renderer #(.LEAD_BLANK(1)) dut_a (
    .clock(clock), .reset(reset), .start(start_a), .score(score),
    .origin_x(origin_x), .origin_y(origin_y), .plot_ready(plot_ready),
    .x(x_a), .y(y_a), .colour(col_a), .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  score_renderer #(.LEAD_BLANK(0)) dut_b (
    .clock(clock), .reset(reset), .start(start_b), .score(score),
    .origin_x(origin_x), .origin_y(origin_y), .plot_ready(plot_ready),
    .x(x_b), .y(y_b), .colour(col_b), .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  initial begin
    forever begin
      @(posedge clock);
      #1;
      plot_ready = rnd_mode ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_pix(input string nm, input pix_t act, input pix_t exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d c=%0d, expected x=%0d y=%0d c=%0d",
               nm, act.x, act.y, act.c, exp.x, exp.y, exp.c);
    end
  endtask

  // 16x32 seven-segment font, stroke width 2; middle bar on rows 15-16.
  function automatic logic [2:0] model_col(input int d, input int r, input int c);
    string s;
    bit    lit;
    s   = segs[d];
    lit = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "a": if (r <= 1) lit = 1'b1;
        "b": if (c >= 14 && r <= 15) lit = 1'b1;
        "c": if (c >= 14 && r >= 16) lit = 1'b1;
        "d": if (r >= 30) lit = 1'b1;
        "e": if (c <= 1 && r >= 16) lit = 1'b1;
        "f": if (c <= 1 && r <= 15) lit = 1'b1;
        "g": if (r == 15 || r == 16) lit = 1'b1;
        default: ;
      endcase
    end
    return lit ? 3'(d % 7 + 1) : 3'd0;
  endfunction

  task automatic push_exp(input int which, input int sc, input int ox, input int oy);
    int   dg[4];
    int   pw;
    bit   zrun;
    bit   blank;
    pix_t p;
    pw = 1000;
    for (int i = 0; i < 4; i++) begin
      dg[i] = (sc > 9999) ? 9 : (sc / pw) % 10;
      pw    = pw / 10;
    end
    zrun = 1'b1;
    for (int i = 0; i < 4; i++) begin
      zrun  = zrun && (dg[i] == 0);
      blank = (which == 0) && zrun && (i < 3);
      for (int r = 0; r < 32; r++) begin
        for (int c = 0; c < 16; c++) begin
          p.x = 8'(ox + 16 * i + c);
          p.y = 7'(oy + r);
          p.c = blank ? 3'd0 : model_col(dg[i], r, c);
          if (which == 0) q_a.push_back(p);
          else            q_b.push_back(p);
        end
      end
    end
  endtask

  always @(negedge clock) begin
    cur_a = '{x: x_a, y: y_a, c: col_a};
    if (plot_a && hold_vld_a) chk_pix("hold_stable", cur_a, held_a);
    hold_vld_a = plot_a && !plot_ready;
    held_a     = cur_a;
    if (plot_a && plot_ready) begin
      if (q_a.size() == 0) begin
        chk("unexpected_plot_a", 1, 0);
      end else begin
        chk_pix("pixel_a", cur_a, q_a.pop_front());
      end
      if (pix_a == 0) first_a = cur_a;
      last_a = cur_a;
      pix_a++;
    end
  end

  always @(negedge clock) begin
    cur_b = '{x: x_b, y: y_b, c: col_b};
    if (plot_b && plot_ready) begin
      if (q_b.size() == 0) begin
        chk("unexpected_plot_b", 1, 0);
      end else begin
        chk_pix("pixel_b", cur_b, q_b.pop_front());
      end
      pix_b++;
    end
  end

  task automatic run(input int which, input int sc, input int ox, input int oy,
                     input bit check_len, input bit inject, input bit start_at_done);
    int t0;
    bit seen;
    push_exp(which, sc, ox, oy);
    @(negedge clock);
    pix_a = 0;
    pix_b = 0;
    score = 14'(sc);
    origin_x = 8'(ox);
    origin_y = 7'(oy);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    t0 = cyc;
    @(negedge clock);
    start_a = 1'b0;
    start_b = 1'b0;
    score = 14'd9999;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      if (inject && (k % 700 == 300)) start_a = 1'b1;
      else start_a = 1'b0;
      if ((which == 0) ? done_a : done_b) seen = 1'b1;
      else @(negedge clock);
    end
    start_a = 1'b0;
    chk("done_seen", int'(seen), 1);
    if (check_len) chk("done_cycle", cyc - t0 + 1, 1 + 14 + 4096 + 1);
    if (start_at_done) start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    chk("done_one_cycle", int'((which == 0) ? done_a : done_b), 0);
    chk("busy_after_done", int'((which == 0) ? busy_a : busy_b), 0);
    chk("pixel_count", (which == 0) ? pix_a : pix_b, 2048);
    chk("queue_drained", (which == 0) ? q_a.size() : q_b.size(), 0);
  endtask

  task automatic reset_mid_plot();
    int k;
    int nplots;
    push_exp(0, 1234, 8, 4);
    @(negedge clock);
    pix_a = 0;
    score = 14'd1234;
    origin_x = 8'd8;
    origin_y = 7'd4;
    start_a = 1'b1;
    @(negedge clock);
    start_a = 1'b0;
    for (k = 0; k < 3000 && pix_a < 100; k++) @(negedge clock);
    chk("reach_100_pixels", int'(pix_a >= 100), 1);
    while (!plot_a && k < 3100) begin
      @(negedge clock);
      k++;
    end
    #2 reset = 1'b1;
    #1;
    chk("reset_plot_low", int'(plot_a), 0);
    chk("reset_busy_low", int'(busy_a), 0);
    q_a.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    nplots = 0;
    repeat (50) begin
      @(negedge clock);
      if (plot_a) nplots++;
    end
    chk("no_plot_after_reset", nplots, 0);
  endtask

  initial begin
    #23;
    chk("rst_x", int'(x_a), 0);
    chk("rst_y", int'(y_a), 0);
    chk("rst_colour", int'(col_a), 0);
    chk("rst_plot", int'(plot_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_done", int'(done_a), 0);
    @(negedge clock);
    reset = 1'b0;

    reset_mid_plot();

    run(0, 1234, 8, 4, 1'b1, 1'b0, 1'b0);
    chk("first_x", int'(first_a.x), 8);
    chk("first_y", int'(first_a.y), 4);
    chk("last_x", int'(last_a.x), 71);
    chk("last_y", int'(last_a.y), 35);

    run(0, 7, 0, 0, 1'b1, 1'b0, 1'b0);
    run(1, 7, 0, 0, 1'b1, 1'b0, 1'b0);
    run(0, 0, 20, 50, 1'b0, 1'b0, 1'b0);
    run(0, 12000, 100, 90, 1'b0, 1'b0, 1'b0);

    rnd_mode = 1'b1;
    run(0, 5678, 30, 10, 1'b0, 1'b1, 1'b0);
    rnd_mode = 1'b0;
    repeat (2) @(negedge clock);

    run(0, 42, 250, 0, 1'b1, 1'b0, 1'b1);
    chk("wrap_first_x", int'(first_a.x), 250);
    chk("wrap_last_x", int'(last_a.x), 57);
    chk("wrap_last_y", int'(last_a.y), 31);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
